// File: rtl/rotate_left_seq_amisha_if.sv
// Valid/ready operand and result port bundle for rotate_left_seq_amisha.
// The producer/consumer side uses master and the rotate unit uses slave.
interface rotate_left_seq_amisha_if #(
  parameter int DATA_W = 8,
  parameter int AMT_W  = 3
);
  logic              in_valid_amisha;
  logic              in_ready_amisha;
  logic [DATA_W-1:0] a_amisha;
  logic [AMT_W-1:0]  amt_amisha;
  logic [DATA_W-1:0] y_amisha;
  logic              out_valid_amisha;
  logic              out_ready_amisha;
  logic              busy_amisha;

  modport master (
    output in_valid_amisha, a_amisha, amt_amisha, out_ready_amisha,
    input  in_ready_amisha, y_amisha, out_valid_amisha, busy_amisha
  );

  modport slave (
    input  in_valid_amisha, a_amisha, amt_amisha, out_ready_amisha,
    output in_ready_amisha, y_amisha, out_valid_amisha, busy_amisha
  );
endinterface

// File: rtl/rotate_left_seq_amisha.sv
// Sequential rotate-left unit (undoes the rotate-right barrel shifter), IDLE/SHIFT/DONE FSM.
// Define ROTATE_LEFT_SEQ_LOG_STEP_EN for fixed AMT_W-cycle power-of-two steps instead of 1 bit/cycle.
module rotate_left_seq_amisha #(
  parameter int DATA_W = 8,
  parameter int AMT_W  = 3
) (
  input  logic                    clk_amisha,
  input  logic                    reset_n_amisha,
  rotate_left_seq_amisha_if.slave bus_amisha
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] work_q, work_d;
  logic [AMT_W-1:0]  cnt_q, cnt_d;
`ifdef ROTATE_LEFT_SEQ_LOG_STEP_EN
  logic [AMT_W-1:0]  amt_q, amt_d;
  logic [AMT_W-1:0]  amt_sh_s;
`endif

  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] w, input int unsigned s);
    logic [2*DATA_W-1:0] dbl;
    dbl = {w, w} << s;
    return dbl[2*DATA_W-1 -: DATA_W];
  endfunction

  // Next-state, work-register and counter update.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
`ifdef ROTATE_LEFT_SEQ_LOG_STEP_EN
    amt_d    = amt_q;
    amt_sh_s = amt_q >> cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus_amisha.in_valid_amisha) begin
          work_d = bus_amisha.a_amisha;
`ifdef ROTATE_LEFT_SEQ_LOG_STEP_EN
          // cnt_q indexes the amount bit, MSB first; every amount walks all steps.
          amt_d   = bus_amisha.amt_amisha;
          cnt_d   = AMT_W'(AMT_W - 1);
          state_d = SHIFT;
`else
          cnt_d = bus_amisha.amt_amisha;
          if (bus_amisha.amt_amisha == '0) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
`ifdef ROTATE_LEFT_SEQ_LOG_STEP_EN
        if (amt_sh_s[0]) begin
          work_d = rotl(work_q, 32'd1 << cnt_q);
        end else begin
          work_d = work_q;
        end
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q - AMT_W'(1);
          state_d = SHIFT;
        end
`else
        work_d = rotl(work_q, 32'd1);
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
`endif
      end
      DONE: begin
        if (bus_amisha.out_ready_amisha) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operand.
  always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
    if (!reset_n_amisha) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
`ifdef ROTATE_LEFT_SEQ_LOG_STEP_EN
      amt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
`ifdef ROTATE_LEFT_SEQ_LOG_STEP_EN
      amt_q   <= amt_d;
`endif
    end
  end

  assign bus_amisha.y_amisha         = work_q;
  assign bus_amisha.in_ready_amisha  = (state_q == IDLE);
  assign bus_amisha.out_valid_amisha = (state_q == DONE);
  assign bus_amisha.busy_amisha      = (state_q != IDLE);

endmodule
